key_event: RTL and testbench

- Upstream input-conditioning stage for push-button counters and menu logic on the board.
- Takes one raw active-low push-button line and synchronises and debounces it.
- Produces one-cycle event pulses for press, release, long-press and auto-repeat.
- A downstream counter uses `inc` directly as its count-enable, with no edge detection of its own.

---
 rtl/key_event.sv | 225 ++++++++++++++++++++++
 tb/tb_key_event.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/key_event.sv
// -----------------------------------------------------------------------------
// key_event
//
// Input conditioning for one raw active-low push button. The raw line passes
// through a two-flop synchroniser and a counter-based debouncer. A three-state
// FSM (IDLE / DOWN / LONG) turns the debounced level into one-cycle event
// pulses for press, release, long-press and auto-repeat.
//
// Ports
//   clk           system clock, all state on the rising edge
//   rst_n         asynchronous active-low reset
//   key           raw button, asynchronous to clk, 0 = pressed
//   repeat_en     1 = emit repeat pulses while in the long-press state
//   pressed       debounced level, 1 while the button is held
//   press_pulse   one cycle on each debounced press
//   release_pulse one cycle on each debounced release
//   long_pulse    one cycle when a hold reaches LONG_N cycles
//   repeat_pulse  one cycle every REPEAT_N cycles in long-press (repeat_en=1)
//   inc           press_pulse | repeat_pulse, a ready-made count enable
//
// Parameters
//   DEBOUNCE_N  cycles the synchronised input must disagree with the
//               debounced state before it flips (>= 2)
//   LONG_N      hold time from press_pulse to long_pulse (> DEBOUNCE_N)
//   REPEAT_N    auto-repeat period once long-press is reached (>= 2)
// -----------------------------------------------------------------------------
module key_event #(
  parameter int DEBOUNCE_N = 1000,
  parameter int LONG_N     = 500000,
  parameter int REPEAT_N   = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key,
  input  logic repeat_en,
  output logic pressed,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic inc
);

  // Counter widths. The hold and repeat counters only ever reach N-1 before
  // they are cleared, so clog2(N) bits are enough.
  localparam int DB_W   = $clog2(DEBOUNCE_N + 1);
  localparam int HOLD_W = $clog2(LONG_N);
  localparam int REP_W  = $clog2(REPEAT_N);

  // Terminal values: the cycle on which the counter would reach its limit.
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_N - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_N - 1);
  localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DOWN = 2'd1,
    LONG = 2'd2
  } state_t;

  // Synchroniser and debouncer state (key polarity kept: 1 = released).
  logic            sync1_r;
  logic            sync2_r;
  logic            deb_r;
  logic [DB_W-1:0] db_cnt_r;
  logic            deb_nxt_s;
  logic [DB_W-1:0] db_cnt_nxt_s;

  // FSM state, counters and registered outputs.
  state_t            state_r;
  state_t            state_nxt_s;
  logic [HOLD_W-1:0] hold_r;
  logic [HOLD_W-1:0] hold_nxt_s;
  logic [REP_W-1:0]  rep_r;
  logic [REP_W-1:0]  rep_nxt_s;
  logic              pressed_r;
  logic              pressed_nxt_s;
  logic              press_r;
  logic              press_nxt_s;
  logic              release_r;
  logic              release_nxt_s;
  logic              long_r;
  logic              long_nxt_s;
  logic              repeat_r;
  logic              repeat_nxt_s;
  logic              key_down_s;

  // Two-flop synchroniser; resets to the released level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= key;
      sync2_r <= sync1_r;
    end
  end

  // Debounce next-state: count consecutive disagreeing cycles, flip on the
  // DEBOUNCE_N-th one. Any agreeing cycle restarts the count, so the counter
  // stays below DEBOUNCE_N and cannot wrap.
  always_comb begin
    deb_nxt_s    = deb_r;
    db_cnt_nxt_s = db_cnt_r;
    if (sync2_r == deb_r) begin
      db_cnt_nxt_s = {DB_W{1'b0}};
    end else if (db_cnt_r >= DB_LAST) begin
      deb_nxt_s    = sync2_r;
      db_cnt_nxt_s = {DB_W{1'b0}};
    end else begin
      db_cnt_nxt_s = db_cnt_r + DB_W'(1'b1);
    end
  end

  // Debounced level and debounce counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_r    <= 1'b1;
      db_cnt_r <= {DB_W{1'b0}};
    end else begin
      deb_r    <= deb_nxt_s;
      db_cnt_r <= db_cnt_nxt_s;
    end
  end

  assign key_down_s = ~deb_r;

  // FSM next-state and next-output logic. Release is tested first in DOWN and
  // LONG so it wins over long_pulse / repeat_pulse on the same cycle.
  always_comb begin
    state_nxt_s   = state_r;
    hold_nxt_s    = hold_r;
    rep_nxt_s     = rep_r;
    pressed_nxt_s = pressed_r;
    press_nxt_s   = 1'b0;
    release_nxt_s = 1'b0;
    long_nxt_s    = 1'b0;
    repeat_nxt_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (key_down_s) begin
          press_nxt_s   = 1'b1;
          pressed_nxt_s = 1'b1;
          hold_nxt_s    = {HOLD_W{1'b0}};
          rep_nxt_s     = {REP_W{1'b0}};
          state_nxt_s   = DOWN;
        end else begin
          pressed_nxt_s = 1'b0;
        end
      end
      DOWN: begin
        if (!key_down_s) begin
          release_nxt_s = 1'b1;
          pressed_nxt_s = 1'b0;
          hold_nxt_s    = {HOLD_W{1'b0}};
          rep_nxt_s     = {REP_W{1'b0}};
          state_nxt_s   = IDLE;
        end else if (hold_r >= HOLD_LAST) begin
          // Hold counter equals LONG_N-1 here, i.e. LONG_N cycles after the
          // press_pulse edge.
          long_nxt_s  = 1'b1;
          rep_nxt_s   = {REP_W{1'b0}};
          state_nxt_s = LONG;
        end else begin
          hold_nxt_s = hold_r + HOLD_W'(1'b1);
        end
      end
      LONG: begin
        if (!key_down_s) begin
          release_nxt_s = 1'b1;
          pressed_nxt_s = 1'b0;
          hold_nxt_s    = {HOLD_W{1'b0}};
          rep_nxt_s     = {REP_W{1'b0}};
          state_nxt_s   = IDLE;
        end else if (rep_r >= REP_LAST) begin
          // The counter keeps running when repeat_en is low so that
          // re-enabling stays on the same REPEAT_N grid.
          rep_nxt_s    = {REP_W{1'b0}};
          repeat_nxt_s = repeat_en;
        end else begin
          rep_nxt_s = rep_r + REP_W'(1'b1);
        end
      end
      default: begin
        state_nxt_s   = IDLE;
        hold_nxt_s    = {HOLD_W{1'b0}};
        rep_nxt_s     = {REP_W{1'b0}};
        pressed_nxt_s = 1'b0;
      end
    endcase
  end

  // FSM state, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      hold_r    <= {HOLD_W{1'b0}};
      rep_r     <= {REP_W{1'b0}};
      pressed_r <= 1'b0;
      press_r   <= 1'b0;
      release_r <= 1'b0;
      long_r    <= 1'b0;
      repeat_r  <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      hold_r    <= hold_nxt_s;
      rep_r     <= rep_nxt_s;
      pressed_r <= pressed_nxt_s;
      press_r   <= press_nxt_s;
      release_r <= release_nxt_s;
      long_r    <= long_nxt_s;
      repeat_r  <= repeat_nxt_s;
    end
  end

  assign pressed       = pressed_r;
  assign press_pulse   = press_r;
  assign release_pulse = release_r;
  assign long_pulse    = long_r;
  assign repeat_pulse  = repeat_r;
  // press and repeat can never coincide (different states), so inc is a
  // clean single-cycle enable.
  assign inc           = press_r | repeat_r;

endmodule

// File: tb/tb_key_event.sv
// -----------------------------------------------------------------------------
// tb_key_event
//
// Directed bench for key_event with DEBOUNCE_N=4, LONG_N=20, REPEAT_N=5.
// Outputs are sampled on the falling clock edge; inputs change right after
// that sample so they are stable at the next rising edge. "cyc" numbers the
// rising edges, and the pulse timestamps below use that numbering.
// -----------------------------------------------------------------------------
module tb_key_event;

  localparam int DB = 4;
  localparam int LN = 20;
  localparam int RN = 5;

  logic clk = 1'b0;
  logic rst_n;
  logic key;
  logic repeat_en;
  logic pressed;
  logic press_pulse;
  logic release_pulse;
  logic long_pulse;
  logic repeat_pulse;
  logic inc;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Per-phase event statistics.
  int n_press, n_rel, n_long, n_rep, n_inc;
  int c_press, c_rel, c_long, c_rep_first, c_rep_last;
  int any_out;
  // Whole-run invariants.
  int inc_dbl = 0;
  int pr_both = 0;
  logic inc_prev = 1'b0;

  int e0;
  int lc;

  key_event #(
    .DEBOUNCE_N(DB),
    .LONG_N    (LN),
    .REPEAT_N  (RN)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key          (key),
    .repeat_en    (repeat_en),
    .pressed      (pressed),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_pulse   (long_pulse),
    .repeat_pulse (repeat_pulse),
    .inc          (inc)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clr_stats();
    n_press = 0; n_rel = 0; n_long = 0; n_rep = 0; n_inc = 0;
    c_press = -1; c_rel = -1; c_long = -1; c_rep_first = -1; c_rep_last = -1;
    any_out = 0;
  endtask

  // Advance n rising edges, sampling outputs on each following falling edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (press_pulse)   begin n_press++; c_press = cyc; end
      if (release_pulse) begin n_rel++;   c_rel   = cyc; end
      if (long_pulse)    begin n_long++;  c_long  = cyc; end
      if (repeat_pulse) begin
        if (n_rep == 0) c_rep_first = cyc;
        n_rep++;
        c_rep_last = cyc;
      end
      if (inc) n_inc++;
      if (inc && inc_prev) inc_dbl++;
      inc_prev = inc;
      if (press_pulse && release_pulse) pr_both++;
      if (press_pulse | release_pulse | long_pulse | repeat_pulse | inc | pressed) any_out++;
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    key       = 1'b1;
    repeat_en = 1'b0;
    clr_stats();

    // Reset, then key released for 50 cycles: nothing may happen.
    step(3);
    check_val("reset_outputs", {26'd0, pressed, press_pulse, release_pulse,
                                long_pulse, repeat_pulse, inc}, 32'd0);
    rst_n = 1'b1;
    clr_stats();
    step(50);
    check_val("idle_any_out", any_out, 32'd0);
    check_val("idle_pressed", pressed, 32'd0);

    // Basic press / release latency: events at E+DB+2.
    clr_stats();
    key = 1'b0;
    e0  = cyc + 1;
    step(10);
    check_val("press_cnt", n_press, 32'd1);
    check_val("press_time", c_press, e0 + DB + 2);
    check_val("pressed_hi", pressed, 32'd1);
    clr_stats();
    key = 1'b1;
    e0  = cyc + 1;
    step(10);
    check_val("release_cnt", n_rel, 32'd1);
    check_val("release_time", c_rel, e0 + DB + 2);
    check_val("pressed_lo", pressed, 32'd0);
    check_val("short_no_long", n_long, 32'd0);

    // Glitches of 1, 2, 3 cycles are filtered.
    clr_stats();
    for (int w = 1; w <= 3; w++) begin
      key = 1'b0;
      step(w);
      key = 1'b1;
      step(10);
    end
    check_val("glitch_press", n_press, 32'd0);
    check_val("glitch_pressed", any_out, 32'd0);
    // A 4-cycle low is exactly long enough.
    clr_stats();
    key = 1'b0;
    step(4);
    key = 1'b1;
    step(12);
    check_val("min_low_press", n_press, 32'd1);
    check_val("min_low_release", n_rel, 32'd1);

    // Long press with repeats enabled.
    clr_stats();
    repeat_en = 1'b1;
    key = 1'b0;
    e0  = cyc + 1;
    step(43);
    check_val("lp_press_time", c_press, e0 + 6);
    check_val("lp_long_time", c_long, e0 + 6 + LN);
    check_val("lp_long_cnt", n_long, 32'd1);
    check_val("lp_rep_cnt", n_rep, 32'd3);
    check_val("lp_rep_first", c_rep_first, e0 + 6 + LN + RN);
    check_val("lp_rep_last", c_rep_last, e0 + 6 + LN + 3 * RN);
    check_val("lp_inc_cnt", n_inc, 32'd4);
    clr_stats();
    repeat_en = 1'b0;
    key = 1'b1;
    step(10);
    check_val("lp_release_cnt", n_rel, 32'd1);

    // Repeat gating and release priority over a repeat.
    clr_stats();
    key = 1'b0;
    e0  = cyc + 1;
    lc  = e0 + 6 + LN;          // expected long_pulse edge
    step(lc + 7 - cyc);         // repeat_en low for edges lc+1 .. lc+7
    repeat_en = 1'b1;
    step(1);
    key = 1'b1;                 // sampled at lc+9 -> release at lc+15
    step(12);
    check_val("rg_long_time", c_long, lc);
    check_val("rg_rep_cnt", n_rep, 32'd1);
    check_val("rg_rep_time", c_rep_first, lc + 2 * RN);
    check_val("rg_release_time", c_rel, lc + 3 * RN);
    check_val("rg_release_cnt", n_rel, 32'd1);
    check_val("rg_inc_cnt", n_inc, 32'd2);

    // Reset while in LONG with key still held.
    clr_stats();
    key = 1'b0;
    step(35);
    check_val("rst_in_long", n_long, 32'd1);
    check_val("rst_pre_pressed", pressed, 32'd1);
    clr_stats();
    #2;
    rst_n = 1'b0;
    #1;
    check_val("rst_async_out", {26'd0, pressed, press_pulse, release_pulse,
                                long_pulse, repeat_pulse, inc}, 32'd0);
    step(3);
    check_val("rst_no_release", n_rel, 32'd0);
    check_val("rst_hold_out", any_out, 32'd0);
    rst_n = 1'b1;
    clr_stats();
    e0 = cyc + 1;
    step(8);
    check_val("rst_repress_cnt", n_press, 32'd1);
    check_val("rst_repress_time", c_press, e0 + DB + 2);
    check_val("rst_repress_norel", n_rel, 32'd0);

    // Whole-run pulse invariants.
    check_val("inc_back_to_back", inc_dbl, 32'd0);
    check_val("press_and_release", pr_both, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
